morse_playback_sequencer: RTL and testbench

Plays back the 10-bit seminibble Morse encoding of the quiz letter (output of the scan-to-Morse lookup) as a timed on/off lamp signal, so the player can hear or see the target pattern before keying an answer. It sits between the quiz control FSM and the lamp/buzzer output. The control FSM requests playback with a start pulse, and the sequencer signals completion with a one-cycle done pulse. The sequencer owns the single lamp resource for the duration of playback.

---
 rtl/morse_playback_sequencer.sv | 143 ++++++++++++++
 tb/tb_morse_playback_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : morse_playback_sequencer
// Description : Plays a 10-bit seminibble Morse code (pair [9:8] first,
//               10=dot, 11=dash, 0x=end) as a timed lamp/buzzer signal.
//               A dot lights the lamp for one unit and a dash for three units.
//               Elements are separated by a one-unit gap. There is no gap
//               after the last element, and completion is flagged with a
//               one-cycle done pulse.
// Ports       : clk           - clock
//               reset         - synchronous, active-low reset
//               i_start       - playback request, sampled only in IDLE
//               i_abort       - cancels playback; no done pulse follows
//               i_morse_code  - seminibble code, latched on accepted start
//               o_lamp_on     - registered lamp/buzzer drive
//               o_busy        - high while an element or gap is playing
//               o_done        - one-cycle pulse on normal completion
//               o_element_idx - index (0-4) of the element being played
// Revision    : 1.0 - initial release
// ============================================================================
module morse_playback_sequencer #(
    parameter int UNIT_CYCLES = 12500000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [9:0] i_morse_code,
    output logic       o_lamp_on,
    output logic       o_busy,
    output logic       o_done,
    output logic [2:0] o_element_idx
);

    localparam logic [CNT_W-1:0] c_DOT_LOAD  = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DASH_LOAD = CNT_W'(3 * UNIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MARK   = 2'd1,
        S_GAP    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [9:0]       r_sr;
    logic [9:0]       w_sr_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic             r_lamp;
    logic             r_busy;
    logic             r_done;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                // Abort beats a simultaneous start in IDLE.
                if (i_start && !i_abort) begin
                    w_sr_nxt  = i_morse_code;
                    w_idx_nxt = 3'd0;
                    if (!i_morse_code[9]) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_MARK;
                        w_cnt_nxt   = (i_morse_code[9:8] == 2'b11) ? c_DASH_LOAD : c_DOT_LOAD;
                    end
                end
            end
            S_MARK: begin
                if (w_cnt_zero) begin
                    w_sr_nxt = {r_sr[7:0], 2'b00};
                    // r_sr[7] is bit 9 of the shifted register: the next pair's lead bit.
                    if (r_idx == 3'd4 || !r_sr[7]) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = c_DOT_LOAD;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_MARK;
                    w_idx_nxt   = r_idx + 3'd1;
                    w_cnt_nxt   = (r_sr[9:8] == 2'b11) ? c_DASH_LOAD : c_DOT_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (i_abort && r_state != S_IDLE) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Outputs are decoded from the next state so they line up with r_state
    // while still coming straight from flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_lamp  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_lamp  <= (w_state_nxt == S_MARK);
            r_busy  <= (w_state_nxt == S_MARK) || (w_state_nxt == S_GAP);
            r_done  <= (w_state_nxt == S_FINISH);
        end
    end

    assign o_lamp_on     = r_lamp;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_element_idx = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_morse_playback_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_playback_sequencer
// Description : Directed self-checking bench for morse_playback_sequencer
//               with UNIT_CYCLES=4. Each scenario task drives stimulus,
//               captures the lamp/busy/done waveform and compares it with
//               hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_morse_playback_sequencer;

    logic       clk;
    logic       reset;
    logic       i_start;
    logic       i_abort;
    logic [9:0] i_morse_code;
    logic       o_lamp_on;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_element_idx;

    int errors = 0;
    int checks = 0;

    // Capture results (cycle 1 = first cycle after the start edge)
    logic [127:0] pat;
    int lamp_hi, busy_hi, done_cnt, done_cyc, rises;
    logic [2:0] first_idx, last_idx;

    morse_playback_sequencer #(.UNIT_CYCLES(4), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_morse_code  (i_morse_code),
        .o_lamp_on     (o_lamp_on),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_element_idx (o_element_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] code);
        i_morse_code = code;
        i_start      = 1'b1;
        tick();
        i_start      = 1'b0;
    endtask

    // Samples max_cyc cycles. After sampling cycle c, start/abort/reset are
    // driven for the edge that closes cycle c when c matches the *_at index.
    task automatic capture(input int max_cyc, input int start_at, input int abort_at,
                           input int reset_at, input logic hold_start);
        logic prev;
        pat = '0; lamp_hi = 0; busy_hi = 0; done_cnt = 0; done_cyc = 0; rises = 0;
        prev = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c > 1) tick();
            pat[c] = o_lamp_on;
            if (o_lamp_on === 1'b1) lamp_hi++;
            if (o_busy === 1'b1) busy_hi++;
            if (o_done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (o_lamp_on === 1'b1 && prev !== 1'b1) rises++;
            prev = o_lamp_on;
            if (c == 1) first_idx = o_element_idx;
            last_idx = o_element_idx;
            i_start = hold_start | (c == start_at);
            i_abort = (c == abort_at);
            reset   = !(c == reset_at);
        end
        i_start = 1'b0;
        i_abort = 1'b0;
        reset   = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; i_start = 1'b1; i_abort = 1'b0; i_morse_code = 10'b1111111111;
        tick(); tick();
        i_start = 1'b0;
        checks++;
        if ({o_lamp_on, o_busy, o_done, o_element_idx} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {o_lamp_on, o_busy, o_done, o_element_idx});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({o_lamp_on, o_busy, o_done} !== 3'b0) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 000", {o_lamp_on, o_busy, o_done});
        end
    endtask

    task automatic test_letter_a();
        pulse_start(10'b1011000000);
        i_morse_code = 10'b1111111111; // must not affect current playback
        capture(24, 0, 0, 0, 1'b0);
        checks++;
        if (pat[31:0] !== 32'h001FFE1E) begin
            errors++; $display("FAIL a_pattern: got %h expected 001ffe1e", pat[31:0]);
        end
        checks++;
        if (busy_hi !== 20) begin errors++; $display("FAIL a_busy: got %0d expected 20", busy_hi); end
        checks++;
        if (done_cyc !== 21 || done_cnt !== 1) begin
            errors++; $display("FAIL a_done: got cyc=%0d cnt=%0d expected cyc=21 cnt=1", done_cyc, done_cnt);
        end
        checks++;
        if (first_idx !== 3'd0 || last_idx !== 3'd1) begin
            errors++; $display("FAIL a_idx: got %0d->%0d expected 0->1", first_idx, last_idx);
        end
    endtask

    task automatic test_zero_digit();
        pulse_start(10'b1111111111);
        capture(84, 0, 0, 0, 1'b0);
        checks++;
        if (lamp_hi !== 60 || rises !== 5) begin
            errors++; $display("FAIL zero_lamp: got hi=%0d rises=%0d expected hi=60 rises=5", lamp_hi, rises);
        end
        checks++;
        if (busy_hi - lamp_hi !== 16) begin
            errors++; $display("FAIL zero_gaps: got %0d expected 16", busy_hi - lamp_hi);
        end
        checks++;
        if (done_cyc !== 77 || done_cnt !== 1) begin
            errors++; $display("FAIL zero_done: got cyc=%0d cnt=%0d expected cyc=77 cnt=1", done_cyc, done_cnt);
        end
        checks++;
        if (first_idx !== 3'd0 || last_idx !== 3'd4) begin
            errors++; $display("FAIL zero_idx: got %0d->%0d expected 0->4", first_idx, last_idx);
        end
    endtask

    task automatic test_empty();
        pulse_start(10'd0);
        capture(6, 0, 0, 0, 1'b0);
        checks++;
        if (done_cyc !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL empty_done: got cyc=%0d cnt=%0d expected cyc=1 cnt=1", done_cyc, done_cnt);
        end
        checks++;
        if (lamp_hi !== 0 || busy_hi !== 0) begin
            errors++; $display("FAIL empty_quiet: got lamp=%0d busy=%0d expected 0 0", lamp_hi, busy_hi);
        end
    endtask

    task automatic test_back_to_back();
        i_morse_code = 10'b1000000000;
        i_start = 1'b1;
        tick();
        capture(12, 0, 0, 0, 1'b1);
        checks++;
        if (pat[15:0] !== 16'h079E) begin
            errors++; $display("FAIL b2b_pattern: got %h expected 079e", pat[15:0]);
        end
        checks++;
        if (done_cnt !== 2 || done_cyc !== 5) begin
            errors++; $display("FAIL b2b_done: got cnt=%0d cyc=%0d expected cnt=2 cyc=5", done_cnt, done_cyc);
        end
        tick(); tick();
    endtask

    task automatic test_start_in_mark();
        pulse_start(10'b1000000000);
        capture(10, 2, 0, 0, 1'b0);
        checks++;
        if (pat[15:0] !== 16'h001E) begin
            errors++; $display("FAIL mark_start_pattern: got %h expected 001e", pat[15:0]);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 5) begin
            errors++; $display("FAIL mark_start_done: got cnt=%0d cyc=%0d expected cnt=1 cyc=5", done_cnt, done_cyc);
        end
    endtask

    task automatic test_abort();
        pulse_start(10'b1100000000);
        capture(14, 0, 6, 0, 1'b0);
        checks++;
        if (pat[15:0] !== 16'h007E || busy_hi !== 6) begin
            errors++; $display("FAIL abort_stop: got pat=%h busy=%0d expected pat=007e busy=6", pat[15:0], busy_hi);
        end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_nodone: got %0d expected 0", done_cnt); end
        pulse_start(10'b1000000000);
        capture(8, 0, 0, 0, 1'b0);
        checks++;
        if (pat[15:0] !== 16'h001E || done_cyc !== 5) begin
            errors++; $display("FAIL abort_replay: got pat=%h done=%0d expected pat=001e done=5", pat[15:0], done_cyc);
        end
    endtask

    task automatic test_abort_start_idle();
        i_morse_code = 10'b1011000000;
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        capture(4, 0, 0, 0, 1'b0);
        checks++;
        if (busy_hi !== 0 || done_cnt !== 0 || lamp_hi !== 0) begin
            errors++; $display("FAIL abort_wins: got busy=%0d done=%0d lamp=%0d expected 0 0 0", busy_hi, done_cnt, lamp_hi);
        end
    endtask

    task automatic test_reset_in_gap();
        pulse_start(10'b1011000000);
        capture(12, 0, 0, 6, 1'b0);
        checks++;
        if (pat[15:0] !== 16'h001E || busy_hi !== 6 || done_cnt !== 0) begin
            errors++; $display("FAIL gap_reset: got pat=%h busy=%0d done=%0d expected 001e 6 0", pat[15:0], busy_hi, done_cnt);
        end
        checks++;
        if (last_idx !== 3'd0) begin errors++; $display("FAIL gap_reset_idx: got %0d expected 0", last_idx); end
        pulse_start(10'b1001000000);
        capture(8, 0, 0, 0, 1'b0);
        checks++;
        if (pat[15:0] !== 16'h001E || busy_hi !== 4) begin
            errors++; $display("FAIL term01_lamp: got pat=%h busy=%0d expected 001e 4", pat[15:0], busy_hi);
        end
        checks++;
        if (done_cyc !== 5 || done_cnt !== 1 || last_idx !== 3'd0) begin
            errors++; $display("FAIL term01_done: got cyc=%0d cnt=%0d idx=%0d expected 5 1 0", done_cyc, done_cnt, last_idx);
        end
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_zero_digit();
        test_empty();
        test_back_to_back();
        test_start_in_mark();
        test_abort();
        test_abort_start_idle();
        test_reset_in_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
